// File: rtl/routing_stage.sv
// Input-channel routing stage: flit FIFO followed by a registered route decision
// and per-port request/grant handshake toward the switch allocator.
module routing_stage #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
    parameter logic [4:0]  DIRECTION       = 5'b00001,
    parameter int          ROUTE_MODE      = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reqIn,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    output logic                          gntIn,
    output logic [4:0]                    reqOutL,
    output logic [4:0]                    reqOutR,
    output logic [4:0]                    reqOutU,
    output logic [4:0]                    reqOutD,
    output logic [4:0]                    reqOutPE,
    output logic [DATA_WIDTH-1:0]         dataOut,
    input  logic                          gntOutL,
    input  logic                          gntOutR,
    input  logic                          gntOutU,
    input  logic                          gntOutD,
    input  logic                          gntOutPE,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] CUR_X = CURRENT_ADDRESS[15:8];
    localparam logic [7:0] CUR_Y = CURRENT_ADDRESS[7:0];

    // Port mask bit order: L, R, U, D, PE.
    localparam logic [4:0] PORT_L  = 5'b00001;
    localparam logic [4:0] PORT_R  = 5'b00010;
    localparam logic [4:0] PORT_U  = 5'b00100;
    localparam logic [4:0] PORT_D  = 5'b01000;
    localparam logic [4:0] PORT_PE = 5'b10000;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;

    logic [DATA_WIDTH-1:0] head_p0;
    logic [4:0]            head_port_p0;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [4:0]            port_p1;

    logic [4:0] gnt_vec;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       drain;

    // 8-bit wrap-around sum is intentional: coordinates live on a torus of 256.
    function automatic logic axis_done(input logic       dir,
                                       input logic [7:0] cur,
                                       input logic [3:0] hop,
                                       input logic [7:0] src);
        logic [7:0] sum;
        sum = (dir ? src : cur) + {4'b0000, hop};
        return dir ? (sum == cur) : (sum == src);
    endfunction

    function automatic logic [4:0] route_sel(input logic       dx,
                                             input logic       dy,
                                             input logic [3:0] hx,
                                             input logic [3:0] hy,
                                             input logic [7:0] sx,
                                             input logic [7:0] sy);
        logic       x_ok;
        logic       y_ok;
        logic [4:0] go_x;
        logic [4:0] go_y;
        x_ok = axis_done(dx, CUR_X, hx, sx);
        y_ok = axis_done(dy, CUR_Y, hy, sy);
        go_x = dx ? PORT_R : PORT_L;
        go_y = dy ? PORT_U : PORT_D;
        if (ROUTE_MODE == 0) begin
            route_sel = !x_ok ? go_x : (!y_ok ? go_y : PORT_PE);
        end else begin
            route_sel = !y_ok ? go_y : (!x_ok ? go_x : PORT_PE);
        end
    endfunction

    assign gnt_vec = {gntOutPE, gntOutD, gntOutU, gntOutR, gntOutL};
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign gntIn   = !full;
    assign push    = reqIn && !full;
    assign drain   = vld_p1 && |(port_p1 & gnt_vec);
    assign pop     = !empty && (!vld_p1 || drain);
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Stage p0: FIFO head and its route, computed combinationally for the load.
    always_comb begin
        head_p0      = mem[rd_ptr];
        head_port_p0 = route_sel(head_p0[62], head_p0[61], head_p0[55:52],
                                 head_p0[51:48], head_p0[47:40], head_p0[39:32]);
    end

    // Stage p1: output register; flit and mask are cleared when nothing is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            port_p1 <= '0;
        end else if (pop) begin
            vld_p1  <= 1'b1;
            data_p1 <= head_p0;
            port_p1 <= head_port_p0;
        end else if (drain) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            port_p1 <= '0;
        end
    end

    assign dataOut  = data_p1;
    assign reqOutL  = port_p1[0] ? DIRECTION : 5'b00000;
    assign reqOutR  = port_p1[1] ? DIRECTION : 5'b00000;
    assign reqOutU  = port_p1[2] ? DIRECTION : 5'b00000;
    assign reqOutD  = port_p1[3] ? DIRECTION : 5'b00000;
    assign reqOutPE = port_p1[4] ? DIRECTION : 5'b00000;

endmodule

// File: tb/tb_routing_stage.sv
// Bench for routing_stage: an XY and a YX instance at router (3,2), checked
// against a behavioural route model and a flit-order queue.
module tb_routing_stage;

    localparam logic [15:0] CUR    = 16'h0302;
    localparam logic [4:0]  DIR_XY = 5'b00100;
    localparam logic [4:0]  DIR_YX = 5'b10000;

    logic        clk;
    logic        reset;
    logic        reqIn;
    logic        reqIn_yx;
    logic [63:0] dataIn;
    logic [4:0]  gnt_xy;
    logic [4:0]  gnt_yx;

    logic        gi_xy, gi_yx;
    logic [4:0]  rL_xy, rR_xy, rU_xy, rD_xy, rP_xy;
    logic [4:0]  rL_yx, rR_yx, rU_yx, rD_yx, rP_yx;
    logic [63:0] do_xy, do_yx;
    logic [2:0]  cnt_xy, cnt_yx;
    logic [24:0] rq_xy, rq_yx;

    int checks = 0;
    int errors = 0;

    assign rq_xy = {rP_xy, rD_xy, rU_xy, rR_xy, rL_xy};
    assign rq_yx = {rP_yx, rD_yx, rU_yx, rR_yx, rL_yx};

    routing_stage #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .CURRENT_ADDRESS(CUR),
                    .DIRECTION(DIR_XY), .ROUTE_MODE(0)) dut_xy (
        .clk(clk), .reset(reset), .reqIn(reqIn), .dataIn(dataIn), .gntIn(gi_xy),
        .reqOutL(rL_xy), .reqOutR(rR_xy), .reqOutU(rU_xy), .reqOutD(rD_xy), .reqOutPE(rP_xy),
        .dataOut(do_xy),
        .gntOutL(gnt_xy[0]), .gntOutR(gnt_xy[1]), .gntOutU(gnt_xy[2]), .gntOutD(gnt_xy[3]),
        .gntOutPE(gnt_xy[4]), .count(cnt_xy));

    routing_stage #(.DATA_WIDTH(64), .FIFO_DEPTH(4), .CURRENT_ADDRESS(CUR),
                    .DIRECTION(DIR_YX), .ROUTE_MODE(1)) dut_yx (
        .clk(clk), .reset(reset), .reqIn(reqIn_yx), .dataIn(dataIn), .gntIn(gi_yx),
        .reqOutL(rL_yx), .reqOutR(rR_yx), .reqOutU(rU_yx), .reqOutD(rD_yx), .reqOutPE(rP_yx),
        .dataOut(do_yx),
        .gntOutL(gnt_yx[0]), .gntOutR(gnt_yx[1]), .gntOutU(gnt_yx[2]), .gntOutD(gnt_yx[3]),
        .gntOutPE(gnt_yx[4]), .count(cnt_yx));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference route: one-hot mask in L,R,U,D,PE order from plain integer arithmetic.
    function automatic logic [4:0] ref_port(input logic [63:0] f, input int mode);
        int cx, cy, hx, hy, sx, sy;
        bit xr, yr;
        logic [4:0] go_x, go_y;
        cx = int'(CUR[15:8]);  cy = int'(CUR[7:0]);
        hx = int'(f[55:52]);   hy = int'(f[51:48]);
        sx = int'(f[47:40]);   sy = int'(f[39:32]);
        xr = f[62] ? (((sx + hx) % 256) == cx) : (((cx + hx) % 256) == sx);
        yr = f[61] ? (((sy + hy) % 256) == cy) : (((cy + hy) % 256) == sy);
        go_x = f[62] ? 5'b00010 : 5'b00001;
        go_y = f[61] ? 5'b00100 : 5'b01000;
        if (mode == 0) return !xr ? go_x : (!yr ? go_y : 5'b10000);
        return !yr ? go_y : (!xr ? go_x : 5'b10000);
    endfunction

    function automatic logic [24:0] exp_req(input logic [4:0] m, input logic [4:0] d);
        logic [24:0] r;
        r = '0;
        for (int p = 0; p < 5; p++) if (m[p]) r[p*5 +: 5] = d;
        return r;
    endfunction

    function automatic logic [63:0] mk_flit(input logic dx, input logic dy,
                                            input logic [3:0] hx, input logic [3:0] hy,
                                            input logic [7:0] sx, input logic [7:0] sy);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[62] = dx; f[61] = dy;
        f[55:52] = hx; f[51:48] = hy;
        f[47:40] = sx; f[39:32] = sy;
        return f;
    endfunction

    // Random header, biased so roughly half of the axes are already resolved.
    function automatic logic [63:0] rand_flit();
        logic       dx, dy;
        logic [3:0] hx, hy;
        logic [7:0] sx, sy, cx, cy;
        cx = CUR[15:8]; cy = CUR[7:0];
        dx = 1'($urandom); dy = 1'($urandom);
        hx = 4'($urandom); hy = 4'($urandom);
        sx = 8'($urandom); sy = 8'($urandom);
        if ($urandom_range(0, 1) == 1) sx = dx ? cx - {4'b0, hx} : cx + {4'b0, hx};
        if ($urandom_range(0, 1) == 1) sy = dy ? cy - {4'b0, hy} : cy + {4'b0, hy};
        return mk_flit(dx, dy, hx, hy, sx, sy);
    endfunction

    task automatic send(input logic [63:0] f, input bit both);
        dataIn = f; reqIn = 1'b1; reqIn_yx = both;
        @(posedge clk); #1;
        reqIn = 1'b0; reqIn_yx = 1'b0;
    endtask

    task automatic flush();
        gnt_xy = 5'h1f; gnt_yx = 5'h1f;
        repeat (8) @(posedge clk);
        #1;
        gnt_xy = '0; gnt_yx = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cnt_xy !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_xy); end
        checks++; if (gi_xy !== 1'b1) begin errors++; $display("FAIL reset_gntIn: got %b expected 1", gi_xy); end
        checks++; if (rq_xy !== 25'd0) begin errors++; $display("FAIL reset_req: got %h expected 0", rq_xy); end
        checks++; if (do_xy !== 64'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", do_xy); end
        checks++; if (rq_yx !== 25'd0 || cnt_yx !== 3'd0) begin errors++; $display("FAIL reset_yx: req %h count %0d expected 0/0", rq_yx, cnt_yx); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_xy_basic();
        logic [63:0] f;
        f = mk_flit(1'b1, 1'b1, 4'd2, 4'd1, 8'h01, 8'h01);
        send(f, 1'b1);
        checks++; if (rq_xy !== 25'd0) begin errors++; $display("FAIL basic_latency: got %h expected 0 one cycle after accept", rq_xy); end
        @(posedge clk); #1;
        checks++; if (rq_xy !== exp_req(5'b10000, DIR_XY)) begin errors++; $display("FAIL basic_pe_req: got %h expected %h", rq_xy, exp_req(5'b10000, DIR_XY)); end
        checks++; if (do_xy !== f) begin errors++; $display("FAIL basic_pe_data: got %h expected %h", do_xy, f); end
        checks++; if (rq_yx !== exp_req(5'b10000, DIR_YX)) begin errors++; $display("FAIL basic_pe_yx: got %h expected %h", rq_yx, exp_req(5'b10000, DIR_YX)); end
        flush();
        f = mk_flit(1'b1, 1'b1, 4'd1, 4'd1, 8'h01, 8'h01);
        send(f, 1'b1);
        @(posedge clk); #1;
        checks++; if (rq_xy !== exp_req(5'b00010, DIR_XY)) begin errors++; $display("FAIL basic_r_req: got %h expected %h", rq_xy, exp_req(5'b00010, DIR_XY)); end
        checks++; if (do_xy !== f) begin errors++; $display("FAIL basic_r_data: got %h expected %h", do_xy, f); end
        flush();
    endtask

    task automatic test_mode_compare();
        logic [63:0] f;
        f = mk_flit(1'b0, 1'b0, 4'd1, 4'd1, 8'h02, 8'h02);
        send(f, 1'b1);
        @(posedge clk); #1;
        checks++; if (rq_xy !== exp_req(5'b00001, DIR_XY)) begin errors++; $display("FAIL mode_xy_l: got %h expected %h", rq_xy, exp_req(5'b00001, DIR_XY)); end
        checks++; if (rq_yx !== exp_req(5'b01000, DIR_YX)) begin errors++; $display("FAIL mode_yx_d: got %h expected %h", rq_yx, exp_req(5'b01000, DIR_YX)); end
        flush();
    endtask

    task automatic test_wrap();
        logic [63:0] f;
        f = mk_flit(1'b1, 1'b1, 4'd5, 4'd0, 8'hFE, 8'h02);
        send(f, 1'b1);
        @(posedge clk); #1;
        checks++; if (rq_xy !== exp_req(5'b10000, DIR_XY)) begin errors++; $display("FAIL wrap_pe: got %h expected %h", rq_xy, exp_req(5'b10000, DIR_XY)); end
        flush();
        f = mk_flit(1'b1, 1'b1, 4'd5, 4'd0, 8'hFE, 8'h01);
        send(f, 1'b1);
        @(posedge clk); #1;
        checks++; if (rq_xy !== exp_req(5'b00100, DIR_XY)) begin errors++; $display("FAIL wrap_u: got %h expected %h", rq_xy, exp_req(5'b00100, DIR_XY)); end
        flush();
    endtask

    task automatic test_random_routes();
        logic [63:0] f;
        for (int i = 0; i < 24; i++) begin
            f = rand_flit();
            send(f, 1'b1);
            @(posedge clk); #1;
            checks++; if (rq_xy !== exp_req(ref_port(f, 0), DIR_XY) || do_xy !== f) begin errors++; $display("FAIL rand_xy[%0d]: got req %h data %h expected req %h data %h", i, rq_xy, do_xy, exp_req(ref_port(f, 0), DIR_XY), f); end
            checks++; if (rq_yx !== exp_req(ref_port(f, 1), DIR_YX) || do_yx !== f) begin errors++; $display("FAIL rand_yx[%0d]: got req %h data %h expected req %h data %h", i, rq_yx, do_yx, exp_req(ref_port(f, 1), DIR_YX), f); end
            flush();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] q[$];
        logic [63:0] nf;
        int acc;
        acc = 0;
        nf = rand_flit();
        for (int cyc = 0; cyc < 10; cyc++) begin
            dataIn = nf; reqIn = 1'b1;
            @(negedge clk);
            if (gi_xy) begin q.push_back(nf); acc++; nf = rand_flit(); end
            @(posedge clk); #1;
        end
        reqIn = 1'b0;
        checks++; if (acc !== 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", acc); end
        checks++; if (cnt_xy !== 3'd4) begin errors++; $display("FAIL bp_count: got %0d expected 4", cnt_xy); end
        checks++; if (gi_xy !== 1'b0) begin errors++; $display("FAIL bp_gntIn: got %b expected 0", gi_xy); end
        checks++; if (do_xy !== q[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", do_xy, q[0]); end
        gnt_xy = 5'h1f;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            void'(q.pop_front());
            checks++; if (do_xy !== q[0] || cnt_xy !== 3'(3 - i)) begin errors++; $display("FAIL bp_drain[%0d]: got data %h count %0d expected %h %0d", i, do_xy, cnt_xy, q[0], 3 - i); end
        end
        @(posedge clk); #1;
        gnt_xy = '0;
        checks++; if (rq_xy !== 25'd0 || do_xy !== 64'd0) begin errors++; $display("FAIL bp_empty: got req %h data %h expected 0 0", rq_xy, do_xy); end
    endtask

    task automatic test_simul_pushpop();
        logic [63:0] f[4];
        logic [24:0] held;
        for (int i = 0; i < 4; i++) f[i] = rand_flit();
        for (int i = 0; i < 3; i++) send(f[i], 1'b0);
        checks++; if (cnt_xy !== 3'd2) begin errors++; $display("FAIL pp_count_before: got %0d expected 2", cnt_xy); end
        dataIn = f[3]; reqIn = 1'b1; gnt_xy = ref_port(f[0], 0);
        @(posedge clk); #1;
        reqIn = 1'b0; gnt_xy = '0;
        checks++; if (cnt_xy !== 3'd2) begin errors++; $display("FAIL pp_count_after: got %0d expected 2", cnt_xy); end
        checks++; if (do_xy !== f[1]) begin errors++; $display("FAIL pp_next: got %h expected %h", do_xy, f[1]); end
        held = exp_req(ref_port(f[1], 0), DIR_XY);
        gnt_xy = ~ref_port(f[1], 0);
        repeat (2) @(posedge clk);
        #1;
        gnt_xy = '0;
        checks++; if (do_xy !== f[1] || rq_xy !== held || cnt_xy !== 3'd2) begin errors++; $display("FAIL pp_wrong_grant: got data %h req %h count %0d expected %h %h 2", do_xy, rq_xy, cnt_xy, f[1], held); end
        gnt_xy = 5'h1f;
        for (int i = 2; i < 4; i++) begin
            @(posedge clk); #1;
            checks++; if (do_xy !== f[i]) begin errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, do_xy, f[i]); end
        end
        flush();
    endtask

    task automatic test_async_reset();
        logic [63:0] f;
        for (int i = 0; i < 4; i++) send(rand_flit(), 1'b0);
        checks++; if (cnt_xy !== 3'd3 || rq_xy === 25'd0) begin errors++; $display("FAIL ar_prefill: got count %0d req %h expected 3 nonzero", cnt_xy, rq_xy); end
        #3 reset = 1'b1;
        #1;
        checks++; if (cnt_xy !== 3'd0 || rq_xy !== 25'd0 || do_xy !== 64'd0 || gi_xy !== 1'b1) begin errors++; $display("FAIL ar_immediate: got count %0d req %h data %h gntIn %b expected 0 0 0 1", cnt_xy, rq_xy, do_xy, gi_xy); end
        @(posedge clk); #1;
        reset = 1'b0;
        f = mk_flit(1'b0, 1'b1, 4'd1, 4'd3, 8'h04, 8'hFF);
        send(f, 1'b0);
        @(posedge clk); #1;
        checks++; if (do_xy !== f || rq_xy !== exp_req(ref_port(f, 0), DIR_XY)) begin errors++; $display("FAIL ar_fresh: got data %h req %h expected %h %h", do_xy, rq_xy, f, exp_req(ref_port(f, 0), DIR_XY)); end
        flush();
        checks++; if (do_xy !== 64'd0 || cnt_xy !== 3'd0) begin errors++; $display("FAIL ar_no_stale: got data %h count %0d expected 0 0", do_xy, cnt_xy); end
    endtask

    initial begin
        reset = 1'b0; reqIn = 1'b0; reqIn_yx = 1'b0; dataIn = '0;
        gnt_xy = '0; gnt_yx = '0;
        #2;
        test_reset();
        test_xy_basic();
        test_mode_compare();
        test_wrap();
        test_random_routes();
        test_backpressure();
        test_simul_pushpop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/routing_stage.md
# routing_stage

Buffered, registered successor to the combinational route-compute block in the mesh router input path. It accepts flits from one input channel into a parametrised FIFO and computes the output port from the header's direction bits, source address and hop counts. The selected flit is held in an output register with a per-port request/grant handshake. The dimension order (XY or YX) is a build-time mode. One instance sits on each router input channel (L, R, U, D, PE), between the link receiver and the switch allocator.

## Interface
- DATA_WIDTH, 64: flit width; must be >= 64; header fields live in bits 63:32.
- FIFO_DEPTH, 4: input buffer entries; power of two, >= 2.
- CURRENT_ADDRESS, 16'h0000: router coordinate; x = [15:8], y = [7:0].
- DIRECTION, 5'b00001: one-hot tag of this input channel, driven on the selected reqOut field.
- ROUTE_MODE, 0: 0 = XY (resolve x first), 1 = YX (resolve y first).

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqIn  in  1  upstream flit valid.
- dataIn  in  DATA_WIDTH  upstream flit.
- gntIn  out  1  buffer can accept; = (count != FIFO_DEPTH); combinational from state only.
- reqOutL, reqOutR, reqOutU, reqOutD, reqOutPE  out  5 each  DIRECTION on the selected port, 0 elsewhere.
- dataOut  out  DATA_WIDTH  held flit; 0 when no flit is held.
- gntOutL, gntOutR, gntOutU, gntOutD, gntOutPE  in  1 each  allocator grant for that port.
- count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, excluding the output register.

## Operation
- Header fields: dir_x = bit 62, dir_y = bit 61, hop_x = [55:52], hop_y = [51:48], src_x = [47:40], src_y = [39:32].
- X resolved:
  - If dir_x = 1: (src_x + hop_x) mod 256 == cur_x.
  - If dir_x = 0: (cur_x + hop_x) mod 256 == src_x.
- Y resolved: same rules using dir_y, hop_y, src_y and cur_y.
- Sums are 8-bit, and wrap-around is intended.
- XY mode:
  - X not resolved: go R if dir_x = 1, else L.
  - X resolved, Y not resolved: go U if dir_y = 1, else D.
  - Both resolved: go PE.
- YX mode: Y is tested first (U/D), then X (R/L), then PE.
- Push: reqIn && gntIn writes dataIn at the write pointer. Pointers wrap modulo FIFO_DEPTH.
- Output register (valid bit, flit, 5-bit one-hot port mask):
  - Drain: valid && gnt of the masked port.
  - Load: FIFO non-empty && (!valid || drain). The FIFO head is popped, and its route is computed and registered in the same cycle.
  - If no load occurs, a drain clears valid.
  - A grant on an unselected port is ignored.
- Flits leave in arrival order. At most one flit per cycle enters the FIFO and at most one leaves it.
- Simultaneous push and pop leaves count unchanged.
- When full, gntIn = 0 even if a pop occurs in the same cycle, so there is no bypass into a full buffer.
- Empty buffer with reqIn: the flit is buffered first. There is no FIFO-bypass path.

## Timing
- Reset (asynchronous, any cycle, including mid-transfer) discards all buffered and held flits. State after reset:
  - count = 0, pointers = 0, valid = 0.
  - All reqOut* = 0, dataOut = 0, gntIn = 1.
- Latency: a flit accepted at edge N is written at edge N and loaded into the output register at edge N+1. reqOut* and dataOut are valid after edge N+1, so minimum latency is 2 cycles.
- A grant sampled at edge M removes the flit at edge M. A following flit already in the FIFO appears after edge M, giving back-to-back throughput of 1 flit/cycle.
- reqOut* and dataOut are driven only from registers, with no combinational path from gntOut*. gntIn depends only on count.
- reqOut* and dataOut stay stable while valid && !grant.

## Test plan
- XY basic, CURRENT_ADDRESS = 16'h0302, dir_x = 1, dir_y = 1, src = (01, 01), hop = (2, 1): reqOutPE = DIRECTION two cycles after acceptance, dataOut = flit, all other reqOut* = 0. Change hop_x to 1: reqOutR = DIRECTION.
- Mode compare, CURRENT_ADDRESS = 16'h0000, src = (02, 02), hop = (1, 1), dir_x = 0, dir_y = 0:
  - ROUTE_MODE = 0: reqOutL.
  - ROUTE_MODE = 1: reqOutD.
- Wrap arithmetic, dir_x = 1, src_x = 8'hFE, hop_x = 3, cur_x = 8'h01: X is resolved, so the flit goes to the Y decision or PE.
- Backpressure, FIFO_DEPTH = 4, no grants, 6 flits offered:
  - 5 accepted (4 in FIFO + 1 in the output register), count = 4, gntIn = 0, the sixth is held upstream.
  - Then continuous grant: flits emerge in order, one per cycle, and count reaches 0 after 4 cycles.
- Simultaneous push/pop at count = 2: count remains 2. A grant on a non-selected port leaves valid = 1 and the outputs unchanged.
- Reset asserted asynchronously mid-stream with 3 flits buffered: outputs go to reset values immediately. After release, a new flit routes with no stale data.
